// File: rtl/mm_operand_issuer.sv
// Operand sequencer for the multiply-and-min core: buffers operand triples, issues one
// operation at a time, and holds the result for a valid/ready consumer. Optional: MM_TIMEOUT_EN.
module mm_operand_issuer #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic [N-1:0]               in_c,
  output logic [N-1:0]               core_a,
  output logic [N-1:0]               core_b,
  output logic [N-1:0]               core_c,
  output logic                       core_start,
  input  logic                       core_ready,
  input  logic [N-1:0]               core_result,
  input  logic                       core_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_result,
  output logic                       out_overflow,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       timeout_flag
);

  // state | meaning
  // IDLE  | waiting for a buffered triple and a free output register
  // ISSUE | core_start pulse, operands held on core_a/b/c
  // GUARD | core_ready ignored while the core drops any stale done flag
  // WAIT  | waiting for core_ready (or the timeout, when enabled)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GUARD + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GUARD < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("mm_operand_issuer: DEPTH must be a power of 2 >= 2, GUARD and TIMEOUT >= 1");
  end

  logic [3*N-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic [1:0]     state;
  logic [GW-1:0]  guard_cnt;
  logic [N-1:0]   head_a;
  logic [N-1:0]   head_b;
  logic [N-1:0]   head_c;
  logic           push;
  logic           pop;
  logic           take;
  logic           done_ok;
  logic           to_hit;
  logic           out_valid_q;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign take     = out_valid_q && out_ready;
  // Pop reads the registered count, so a triple pushed this cycle is never bypassed.
  assign pop      = (state == S_IDLE) && (count_q != '0) && (!out_valid_q || out_ready);
  assign done_ok  = (state == S_WAIT) && core_ready;
  assign {head_a, head_b, head_c} = mem[rd_ptr];

  assign count     = count_q;
  assign busy      = (state != S_IDLE);
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_c};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      guard_cnt  <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_c     <= '0;
      core_start <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            core_a     <= head_a;
            core_b     <= head_b;
            core_c     <= head_c;
            core_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          core_start <= 1'b0;
          guard_cnt  <= GW'(GUARD - 1);
          state      <= S_GUARD;
        end
        S_GUARD: begin
          if (guard_cnt == '0) state <= S_WAIT;
          else                 guard_cnt <= guard_cnt - 1'b1;
        end
        S_WAIT: begin
          if (done_ok || to_hit) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else if (done_ok) begin
      out_valid_q  <= 1'b1;
      out_result   <= core_result;
      out_overflow <= core_overflow;
    end else if (to_hit) begin
      out_valid_q  <= 1'b1;
      out_result   <= '0;
      out_overflow <= 1'b1;
    end else if (take) begin
      out_valid_q  <= 1'b0;
    end
  end

`ifdef MM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // core_ready on the terminal cycle takes priority over the timeout.
  assign to_hit = (state == S_WAIT) && !core_ready && (to_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_GUARD)     to_cnt <= TW'(TIMEOUT - 1);
      else if (state == S_WAIT) to_cnt <= to_cnt - 1'b1;
      if (done_ok)     timeout_flag <= 1'b0;
      else if (to_hit) timeout_flag <= 1'b1;
      else if (take)   timeout_flag <= 1'b0;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mm_operand_issuer.sv
// Directed bench for mm_operand_issuer: single op, stale ready, back-pressure, fill, reset
// mid-WAIT, and the MM_TIMEOUT_EN path when that macro is defined.
module tb_mm_operand_issuer;
  localparam int N = 8;
`ifdef MM_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic [N-1:0] core_a, core_b, core_c;
  logic         core_start;
  logic         core_ready = 1'b0;
  logic [N-1:0] core_result = '0;
  logic         core_overflow = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_result;
  logic         out_overflow;
  logic         busy;
  logic [2:0]   count;
  logic         timeout_flag;

  int n_vec = 0;
  int n_err = 0;

  mm_operand_issuer #(.N(N), .DEPTH(4), .GUARD(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_start(core_start),
    .core_ready(core_ready), .core_result(core_result), .core_overflow(core_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .busy(busy), .count(count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
  endtask

  initial begin
    int exp_cnt [5];
    exp_cnt = '{1, 1, 2, 3, 4};

    // reset state
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_core_a", 32'(core_a), 0);
    chk("rst_timeout_flag", 32'(timeout_flag), 0);
    reset_n = 1'b1;
    step();

    // single op: accept at c0, start at c2, WAIT from c5, ready at c6, out_valid at c7
    out_ready = 1'b1;
    offer(3, 5, 7);
    step();
    in_valid = 1'b0;
    chk("op1_c1_count", 32'(count), 1);
    chk("op1_c1_start", 32'(core_start), 0);
    step();
    chk("op1_c2_start", 32'(core_start), 1);
    chk("op1_c2_operands", 32'({core_a, core_b, core_c}), 32'h030507);
    chk("op1_c2_busy", 32'(busy), 1);
    chk("op1_c2_count", 32'(count), 0);
    step();
    chk("op1_c3_start", 32'(core_start), 0);
    step();
    step();
    chk("op1_c5_busy", 32'(busy), 1);
    chk("op1_c5_out_valid", 32'(out_valid), 0);
    step();
    core_ready = 1'b1;
    core_result = 8'd15;
    core_overflow = 1'b0;
    step();
    core_ready = 1'b0;
    chk("op1_c7_out_valid", 32'(out_valid), 1);
    chk("op1_c7_out_result", 32'(out_result), 15);
    chk("op1_c7_out_overflow", 32'(out_overflow), 0);
    chk("op1_c7_busy", 32'(busy), 0);
    step();
    chk("op1_c8_out_valid", 32'(out_valid), 0);
    chk("op1_c8_core_a_held", 32'(core_a), 3);

    // stale ready held high: ignored in GUARD, captured on first WAIT cycle (c5)
    out_ready = 1'b0;
    core_ready = 1'b1;
    core_result = 8'hAA;
    core_overflow = 1'b1;
    offer(9, 8, 6);
    step();
    in_valid = 1'b0;
    step();
    chk("stale_c2_start", 32'(core_start), 1);
    step();
    chk("stale_c3_out_valid", 32'(out_valid), 0);
    step();
    chk("stale_c4_out_valid", 32'(out_valid), 0);
    step();
    chk("stale_c5_out_valid", 32'(out_valid), 0);
    chk("stale_c5_busy", 32'(busy), 1);
    step();
    core_ready = 1'b0;
    chk("stale_c6_out_valid", 32'(out_valid), 1);
    chk("stale_c6_out_result", 32'(out_result), 32'hAA);
    chk("stale_c6_out_overflow", 32'(out_overflow), 1);

    // back-pressure: result held, no new start until the handshake
    offer(1, 2, 3);
    step();
    in_valid = 1'b0;
    chk("bp_count", 32'(count), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_no_start", 32'(core_start), 0);
    end
    chk("bp_out_valid_held", 32'(out_valid), 1);
    chk("bp_out_result_held", 32'(out_result), 32'hAA);
    chk("bp_count_held", 32'(count), 1);
    out_ready = 1'b1;
    step();
    chk("bp_after_hs_out_valid", 32'(out_valid), 0);
    chk("bp_after_hs_start", 32'(core_start), 1);
    chk("bp_after_hs_operands", 32'({core_a, core_b, core_c}), 32'h010203);
    step();
    step();
    step();
    core_ready = 1'b1;
    core_result = 8'h42;
    core_overflow = 1'b0;
    step();
    core_ready = 1'b0;
    chk("bp_op2_out_valid", 32'(out_valid), 1);
    chk("bp_op2_out_result", 32'(out_result), 32'h42);
    step();
    chk("bp_op2_drained", 32'(out_valid), 0);

    // fill: core stalls in WAIT, five back-to-back offers, one popped at c1
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(8'(16 + i), 8'(32 + i), 8'(48 + i));
      chk("fill_in_ready", 32'(in_ready), 1);
      step();
      chk("fill_count", 32'(count), 32'(exp_cnt[i]));
    end
    offer(8'hEE, 8'hEE, 8'hEE);
    chk("fill_full_in_ready", 32'(in_ready), 0);
    chk("fill_first_popped", 32'(core_a), 16);
    step();
    in_valid = 1'b0;
    chk("fill_refused_count", 32'(count), 4);
    chk("fill_wait_busy", 32'(busy), 1);

    // reset mid-WAIT with buffered triples
    reset_n = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_core_start", 32'(core_start), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    step();
    reset_n = 1'b1;
    core_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mrst_quiet", 32'({out_valid, core_start, busy}), 0);
    end
    core_ready = 1'b0;
    chk("timeout_flag_default", 32'(timeout_flag), 0);

`ifdef MM_TIMEOUT_EN
    // timeout: WAIT c5..c14, timed-out result visible at c15
    out_ready = 1'b0;
    offer(7, 7, 7);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("to_c14_out_valid", 32'(out_valid), 0);
    step();
    chk("to_c15_out_valid", 32'(out_valid), 1);
    chk("to_c15_out_result", 32'(out_result), 0);
    chk("to_c15_out_overflow", 32'(out_overflow), 1);
    chk("to_c15_timeout_flag", 32'(timeout_flag), 1);
    out_ready = 1'b1;
    offer(4, 5, 6);
    step();
    in_valid = 1'b0;
    chk("to_c16_timeout_flag", 32'(timeout_flag), 0);
    chk("to_c16_out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) step();
    core_ready = 1'b1;
    core_result = 8'h21;
    core_overflow = 1'b0;
    step();
    core_ready = 1'b0;
    chk("to_next_out_valid", 32'(out_valid), 1);
    chk("to_next_out_result", 32'(out_result), 32'h21);
    chk("to_next_timeout_flag", 32'(timeout_flag), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
